// File: rtl/br_update_queue.sv
// Buffers resolved branch outcomes and drains them as PHT saturating-counter writes.
// Also runs the post-reset PHT initialization sweep and issues local-history recovery.
module br_update_queue #(
  parameter int ISSUE_WIDTH    = 2,
  parameter int DEPTH          = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int INSN_ADDR_BITS = 2,
  parameter int INDEX_BITS     = 6,
  parameter int HIST_BITS      = 4,
  parameter int CTR_WIDTH      = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ISSUE_WIDTH-1:0]                 in_valid,
  input  logic [ISSUE_WIDTH-1:0][ADDR_WIDTH-1:0] in_addr,
  input  logic [ISSUE_WIDTH-1:0]                 in_taken,
  input  logic [ISSUE_WIDTH-1:0]                 in_mispred,
  input  logic [ISSUE_WIDTH-1:0]                 in_is_cond,
  input  logic [ISSUE_WIDTH-1:0][HIST_BITS-1:0]  in_hist,
  input  logic [ISSUE_WIDTH-1:0][CTR_WIDTH-1:0]  in_ctr,
  output logic                                   in_ready,
  output logic                                   upd_valid,
  input  logic                                   upd_ready,
  output logic [INDEX_BITS-1:0]                  upd_index,
  output logic [HIST_BITS-1:0]                   upd_hist,
  output logic [CTR_WIDTH-1:0]                   upd_ctr,
  output logic                                   rec_valid,
  output logic [INDEX_BITS-1:0]                  rec_index,
  output logic [HIST_BITS-1:0]                   rec_hist,
  output logic                                   init_busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SWEEP_W = INDEX_BITS + HIST_BITS;
  localparam logic [SWEEP_W-1:0]   SWEEP_LAST = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT   = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [SWEEP_W-1:0]   sweep_q, sweep_d;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d, wr_ptr;
  logic [CNT_W-1:0]     count_q, count_d, n_push;
  logic                 pop;

  logic [INDEX_BITS-1:0] q_index_q [DEPTH];
  logic [INDEX_BITS-1:0] q_index_d [DEPTH];
  logic [HIST_BITS-1:0]  q_hist_q  [DEPTH];
  logic [HIST_BITS-1:0]  q_hist_d  [DEPTH];
  logic [CTR_WIDTH-1:0]  q_ctr_q   [DEPTH];
  logic [CTR_WIDTH-1:0]  q_ctr_d   [DEPTH];
  logic                  q_taken_q [DEPTH];
  logic                  q_taken_d [DEPTH];

  logic                  lw_valid_q, lw_valid_d;
  logic [INDEX_BITS-1:0] lw_index_q, lw_index_d;
  logic [HIST_BITS-1:0]  lw_hist_q, lw_hist_d;
  logic [CTR_WIDTH-1:0]  lw_ctr_q, lw_ctr_d;

  logic                  rec_valid_q, rec_valid_d;
  logic [INDEX_BITS-1:0] rec_index_q, rec_index_d;
  logic [HIST_BITS-1:0]  rec_hist_q, rec_hist_d;

  logic [INDEX_BITS-1:0] head_index;
  logic [HIST_BITS-1:0]  head_hist;
  logic [CTR_WIDTH-1:0]  base_ctr, next_ctr;
  logic [CTR_WIDTH:0]    inc_ext;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^in_addr;

  // A write to the same slot in the previous cycle may not be visible in the
  // fetch-time counter, so chain off the value we just wrote instead.
  always_comb begin
    head_index = q_index_q[head_q];
    head_hist  = q_hist_q[head_q];
    base_ctr   = q_ctr_q[head_q];
    if (lw_valid_q && (lw_index_q == head_index) && (lw_hist_q == head_hist)) begin
      base_ctr = lw_ctr_q;
    end
    inc_ext = {1'b0, base_ctr} + {{CTR_WIDTH{1'b0}}, 1'b1};
    if (q_taken_q[head_q]) begin
      next_ctr = inc_ext[CTR_WIDTH] ? base_ctr : inc_ext[CTR_WIDTH-1:0];
    end else begin
      next_ctr = (base_ctr == '0) ? base_ctr : base_ctr - CTR_WIDTH'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    head_d      = head_q;
    count_d     = count_q;
    q_index_d   = q_index_q;
    q_hist_d    = q_hist_q;
    q_ctr_d     = q_ctr_q;
    q_taken_d   = q_taken_q;
    lw_valid_d  = 1'b0;
    lw_index_d  = lw_index_q;
    lw_hist_d   = lw_hist_q;
    lw_ctr_d    = lw_ctr_q;
    rec_valid_d = 1'b0;
    rec_index_d = rec_index_q;
    rec_hist_d  = rec_hist_q;
    wr_ptr      = tail_q;
    n_push      = '0;
    pop         = 1'b0;
    in_ready    = 1'b0;
    upd_valid   = 1'b0;
    upd_index   = sweep_q[SWEEP_W-1 -: INDEX_BITS];
    upd_hist    = sweep_q[HIST_BITS-1:0];
    upd_ctr     = CTR_INIT;
    case (state_q)
      ST_INIT: begin
        upd_valid = !rst;
        if (upd_valid && upd_ready) begin
          sweep_d = sweep_q + SWEEP_W'(1);
          if (sweep_q == SWEEP_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        in_ready  = !rst && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(ISSUE_WIDTH));
        upd_valid = !rst && (count_q != '0);
        upd_index = head_index;
        upd_hist  = head_hist;
        upd_ctr   = next_ctr;
        if (upd_valid && upd_ready) begin
          pop        = 1'b1;
          head_d     = head_q + PTR_W'(1);
          lw_valid_d = 1'b1;
          lw_index_d = head_index;
          lw_hist_d  = head_hist;
          lw_ctr_d   = next_ctr;
        end
        if (in_ready) begin
          for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (in_valid[i] && in_is_cond[i]) begin
              q_index_d[wr_ptr] = in_addr[i][INSN_ADDR_BITS +: INDEX_BITS];
              q_hist_d[wr_ptr]  = in_hist[i];
              q_ctr_d[wr_ptr]   = in_ctr[i];
              q_taken_d[wr_ptr] = in_taken[i];
              wr_ptr            = wr_ptr + PTR_W'(1);
              n_push            = n_push + CNT_W'(1);
            end
          end
        end
        // Scanned high-to-low so the oldest mispredicting lane has the final say.
        for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
          if (in_valid[i] && in_mispred[i] && in_is_cond[i]) begin
            rec_valid_d = 1'b1;
            rec_index_d = in_addr[i][INSN_ADDR_BITS +: INDEX_BITS];
            rec_hist_d  = {in_hist[i][HIST_BITS-2:0], in_taken[i]};
          end
        end
        count_d = count_q + n_push - CNT_W'(pop);
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign tail_d    = wr_ptr;
  assign init_busy = rst || (state_q == ST_INIT);
  assign rec_valid = rec_valid_q;
  assign rec_index = rec_index_q;
  assign rec_hist  = rec_hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      lw_valid_q  <= 1'b0;
      lw_index_q  <= '0;
      lw_hist_q   <= '0;
      lw_ctr_q    <= '0;
      rec_valid_q <= 1'b0;
      rec_index_q <= '0;
      rec_hist_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      lw_valid_q  <= lw_valid_d;
      lw_index_q  <= lw_index_d;
      lw_hist_q   <= lw_hist_d;
      lw_ctr_q    <= lw_ctr_d;
      rec_valid_q <= rec_valid_d;
      rec_index_q <= rec_index_d;
      rec_hist_q  <= rec_hist_d;
    end
  end

  always_ff @(posedge clk) begin
    q_index_q <= q_index_d;
    q_hist_q  <= q_hist_d;
    q_ctr_q   <= q_ctr_d;
    q_taken_q <= q_taken_d;
  end

endmodule

// File: tb/tb_br_update_queue.sv
// Testbench for br_update_queue: directed vector table, reset sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_br_update_queue;

  localparam int IW         = 2;
  localparam int DEPTH      = 8;
  localparam int AW         = 32;
  localparam int IAB        = 2;
  localparam int IB         = 4;
  localparam int HB         = 4;
  localparam int CW         = 2;
  localparam int SWEEP_LEN  = 1 << (IB + HB);
  localparam int CTR_MAX    = (1 << CW) - 1;
  localparam int CTR_INIT   = 1 << (CW - 1);
  localparam int RAND_STEPS = 6000;

  logic clk = 1'b0;
  logic rst;
  logic [IW-1:0]         in_valid, in_taken, in_mispred, in_is_cond;
  logic [IW-1:0][AW-1:0] in_addr;
  logic [IW-1:0][HB-1:0] in_hist;
  logic [IW-1:0][CW-1:0] in_ctr;
  logic                  in_ready, upd_valid, upd_ready, rec_valid, init_busy;
  logic [IB-1:0]         upd_index, rec_index;
  logic [HB-1:0]         upd_hist, rec_hist;
  logic [CW-1:0]         upd_ctr;

  always #5 clk = ~clk;

  br_update_queue #(
    .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSN_ADDR_BITS(IAB),
    .INDEX_BITS(IB), .HIST_BITS(HB), .CTR_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_taken(in_taken),
    .in_mispred(in_mispred), .in_is_cond(in_is_cond), .in_hist(in_hist),
    .in_ctr(in_ctr), .in_ready(in_ready),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_hist(upd_hist), .upd_ctr(upd_ctr),
    .rec_valid(rec_valid), .rec_index(rec_index), .rec_hist(rec_hist),
    .init_busy(init_busy)
  );

  typedef struct {
    logic                  rst;
    logic                  rdy;
    logic [IW-1:0]         valid, taken, mispred, cond;
    logic [IW-1:0][AW-1:0] addr;
    logic [IW-1:0][HB-1:0] hist;
    logic [IW-1:0][CW-1:0] ctr;
    logic                  chk;
    logic                  e_uv, e_ir, e_busy, e_rv;
    int                    e_idx, e_hist, e_ctr, e_ridx, e_rhist;
  } vec_t;

  typedef struct {
    int idx;
    int hist;
    int ctr;
    bit taken;
  } ent_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: a plain FIFO of pending updates plus the sweep position.
  bit   m_init;
  int   m_sweep;
  ent_t mq[$];
  bit   m_lw_v;
  int   m_lw_idx, m_lw_hist, m_lw_ctr;
  bit   m_rec_v;
  int   m_rec_idx, m_rec_hist;
  bit   e_uv, e_ir, e_busy;
  int   e_idx, e_hist, e_ctr;

  function automatic logic [AW-1:0] lane_addr(input int idx);
    return 32'hA5C3_0000 | (32'(idx) << IAB) | 32'd3;
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a >> IAB) % (1 << IB));
  endfunction

  function automatic vec_t mk(input bit r, input bit rdy, input logic [IW-1:0] val,
                              input logic [IW-1:0] tk, input logic [IW-1:0] mp,
                              input logic [IW-1:0] cd, input int i0, input int i1,
                              input int h0, input int h1, input int c0, input int c1);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.valid = val; v.taken = tk; v.mispred = mp; v.cond = cd;
    v.addr[0] = lane_addr(i0); v.addr[1] = lane_addr(i1);
    v.hist[0] = HB'(h0); v.hist[1] = HB'(h1);
    v.ctr[0]  = CW'(c0); v.ctr[1]  = CW'(c1);
    v.chk = 1'b0; v.e_uv = 1'b0; v.e_ir = 1'b0; v.e_busy = 1'b0; v.e_rv = 1'b0;
    v.e_idx = 0; v.e_hist = 0; v.e_ctr = 0; v.e_ridx = 0; v.e_rhist = 0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vin, input bit uv, input int idx, input int hist,
                              input int ctr, input bit ir, input bit busy, input bit rv,
                              input int ridx, input int rhist);
    vec_t v;
    v = vin;
    v.chk = 1'b1; v.e_uv = uv; v.e_idx = idx; v.e_hist = hist; v.e_ctr = ctr;
    v.e_ir = ir; v.e_busy = busy; v.e_rv = rv; v.e_ridx = ridx; v.e_rhist = rhist;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1; m_sweep = 0; mq.delete(); m_lw_v = 1'b0;
    m_rec_v = 1'b0; m_rec_idx = 0; m_rec_hist = 0;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    ent_t h;
    int   base;
    e_idx = 0; e_hist = 0; e_ctr = 0;
    if (v.rst) begin
      e_uv = 1'b0; e_ir = 1'b0; e_busy = 1'b1;
    end else if (m_init) begin
      e_uv = 1'b1; e_ir = 1'b0; e_busy = 1'b1;
      e_idx = m_sweep / (1 << HB); e_hist = m_sweep % (1 << HB); e_ctr = CTR_INIT;
    end else begin
      e_busy = 1'b0;
      e_ir   = (DEPTH - mq.size()) >= IW;
      e_uv   = mq.size() != 0;
      if (e_uv) begin
        h    = mq[0];
        base = (m_lw_v && m_lw_idx == h.idx && m_lw_hist == h.hist) ? m_lw_ctr : h.ctr;
        e_idx = h.idx; e_hist = h.hist;
        e_ctr = h.taken ? ((base + 1 > CTR_MAX) ? CTR_MAX : base + 1)
                        : ((base - 1 < 0) ? 0 : base - 1);
      end
    end
    cmp({tag, " upd_valid"}, 64'(upd_valid), 64'(e_uv));
    cmp({tag, " in_ready"}, 64'(in_ready), 64'(e_ir));
    cmp({tag, " init_busy"}, 64'(init_busy), 64'(e_busy));
    if (e_uv) begin
      cmp({tag, " upd_index"}, 64'(upd_index), 64'(e_idx));
      cmp({tag, " upd_hist"}, 64'(upd_hist), 64'(e_hist));
      cmp({tag, " upd_ctr"}, 64'(upd_ctr), 64'(e_ctr));
    end
    cmp({tag, " rec_valid"}, 64'(rec_valid), 64'(m_rec_v));
    if (m_rec_v) begin
      cmp({tag, " rec_index"}, 64'(rec_index), 64'(m_rec_idx));
      cmp({tag, " rec_hist"}, 64'(rec_hist), 64'(m_rec_hist));
    end
    if (v.chk) begin
      cmp({tag, " vec upd_valid"}, 64'(upd_valid), 64'(v.e_uv));
      cmp({tag, " vec in_ready"}, 64'(in_ready), 64'(v.e_ir));
      cmp({tag, " vec init_busy"}, 64'(init_busy), 64'(v.e_busy));
      cmp({tag, " vec rec_valid"}, 64'(rec_valid), 64'(v.e_rv));
      if (v.e_uv) begin
        cmp({tag, " vec upd_index"}, 64'(upd_index), 64'(v.e_idx));
        cmp({tag, " vec upd_hist"}, 64'(upd_hist), 64'(v.e_hist));
        cmp({tag, " vec upd_ctr"}, 64'(upd_ctr), 64'(v.e_ctr));
      end
      if (v.e_rv) begin
        cmp({tag, " vec rec_index"}, 64'(rec_index), 64'(v.e_ridx));
        cmp({tag, " vec rec_hist"}, 64'(rec_hist), 64'(v.e_rhist));
      end
    end
  endtask

  task automatic model_step(input vec_t v);
    ent_t e;
    bit   found;
    found = 1'b0;
    if (v.rst) begin
      model_reset();
    end else if (m_init) begin
      m_rec_v = 1'b0; m_lw_v = 1'b0;
      if (v.rdy) begin
        m_sweep++;
        if (m_sweep == SWEEP_LEN) m_init = 1'b0;
      end
    end else begin
      m_rec_v = 1'b0;
      for (int i = 0; i < IW; i++) begin
        if (!found && v.valid[i] && v.mispred[i] && v.cond[i]) begin
          found = 1'b1; m_rec_v = 1'b1;
          m_rec_idx  = idx_of(v.addr[i]);
          m_rec_hist = ((int'(v.hist[i]) << 1) | int'(v.taken[i])) % (1 << HB);
        end
      end
      if (e_uv && v.rdy) begin
        m_lw_v = 1'b1; m_lw_idx = e_idx; m_lw_hist = e_hist; m_lw_ctr = e_ctr;
        void'(mq.pop_front());
      end else begin
        m_lw_v = 1'b0;
      end
      if (e_ir) begin
        for (int i = 0; i < IW; i++) begin
          if (v.valid[i] && v.cond[i]) begin
            e.idx = idx_of(v.addr[i]); e.hist = int'(v.hist[i]);
            e.ctr = int'(v.ctr[i]); e.taken = v.taken[i];
            mq.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; upd_ready = v.rdy;
    in_valid = v.valid; in_taken = v.taken; in_mispred = v.mispred; in_is_cond = v.cond;
    in_addr = v.addr; in_hist = v.hist; in_ctr = v.ctr;
    #1;
    checkOutput(v, tag);
    model_step(v);
  endtask

  vec_t tbl[$];
  vec_t idle;
  vec_t v;
  bit   pred_ready;
  logic [31:0] r;

  initial begin
    idle = mk(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    // rows 0-1: reset and first sweep write; rows 2+: after the sweep completes
    tbl.push_back(ex(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 0, 0, 2, 0, 1, 0, 0, 0));
    tbl.push_back(ex(mk(0, 1, 2'b11, 2'b01, 2'b00, 2'b11, 5, 6, 3, 2, 3, 0), 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 5, 3, 3, 1, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 6, 2, 0, 1, 0, 0, 0, 0));
    tbl.push_back(ex(mk(0, 1, 2'b11, 2'b11, 2'b00, 2'b11, 9, 9, 7, 7, 1, 1), 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 9, 7, 2, 1, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 9, 7, 3, 1, 0, 0, 0, 0));
    tbl.push_back(ex(mk(0, 1, 2'b11, 2'b01, 2'b11, 2'b11, 3, 12, 10, 10, 2, 2), 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 3, 10, 3, 1, 0, 1, 3, 5));
    tbl.push_back(ex(idle, 1, 12, 10, 1, 1, 0, 0, 0, 0));
    tbl.push_back(ex(mk(0, 0, 2'b11, 2'b11, 2'b00, 2'b11, 1, 2, 0, 0, 1, 1), 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(ex(mk(0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 4, 4, 1, 1, 0, 0), 1, 1, 0, 2, 1, 0, 0, 0, 0));
    tbl.push_back(ex(mk(0, 0, 2'b11, 2'b11, 2'b00, 2'b11, 7, 7, 0, 0, 2, 2), 1, 1, 0, 2, 1, 0, 0, 0, 0));
    tbl.push_back(ex(mk(0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 8, 8, 0, 0, 2, 2), 1, 1, 0, 2, 1, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 1, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 2, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 4, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 4, 1, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(idle);

    rst = 1'b1; upd_ready = 1'b0; in_valid = '0; in_taken = '0; in_mispred = '0;
    in_is_cond = '0; in_addr = '0; in_hist = '0; in_ctr = '0;
    repeat (2) @(posedge clk);
    model_reset();

    for (int i = 0; i < 2; i++) applyStimulus(tbl[i], $sformatf("row%0d", i));
    for (int i = 1; i < SWEEP_LEN; i++) applyStimulus(idle, "sweep");
    for (int i = 2; i < tbl.size(); i++) applyStimulus(tbl[i], $sformatf("row%0d", i));

    $display("[TB] reset with entries queued");
    applyStimulus(mk(0, 0, 2'b11, 2'b11, 2'b00, 2'b11, 10, 11, 1, 2, 1, 2), "fill0");
    applyStimulus(mk(0, 0, 2'b11, 2'b00, 2'b00, 2'b11, 12, 13, 3, 4, 3, 3), "fill1");
    applyStimulus(mk(0, 0, 2'b11, 2'b01, 2'b00, 2'b10, 14, 15, 5, 6, 0, 1), "fill2");
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "hold");
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst0");
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst1");
    for (int i = 0; i < SWEEP_LEN; i++) applyStimulus(idle, "resweep");
    for (int i = 0; i < 4; i++) applyStimulus(idle, "drained");
    cmp("no_stale_entries upd_valid", 64'(upd_valid), 64'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < RAND_STEPS; n++) begin
      v = mk($urandom_range(999) == 0, $urandom_range(9) < 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      pred_ready = !v.rst && !m_init && ((DEPTH - mq.size()) >= IW);
      for (int i = 0; i < IW; i++) begin
        r = $urandom();
        v.addr[i]    = (r & ~32'h3C) | (32'($urandom_range(3)) << IAB);
        v.valid[i]   = pred_ready && ($urandom_range(1) == 1);
        v.cond[i]    = $urandom_range(3) != 0;
        v.taken[i]   = $urandom_range(1) == 1;
        v.mispred[i] = $urandom_range(3) == 0;
        v.hist[i]    = HB'($urandom_range(1));
        v.ctr[i]     = CW'($urandom_range(CTR_MAX));
      end
      applyStimulus(v, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_update_queue.md
# br_update_queue

Execution-side producer for the local-history (PAp) branch predictor's update interface. Collects resolved branch results from the integer issue lanes and buffers them in order. Drains them one per cycle as saturating-counter write requests to the predictor's PHT, avoiding the same-bank/same-address write collisions the predictor drops. Also issues the post-reset PHT initialization sweep and a registered local-history recovery request on conditional-branch mispredictions.

## Interface
- ISSUE_WIDTH, 2, number of branch-result lanes per cycle
- DEPTH, 8, queue entries; power of two, ≥ ISSUE_WIDTH
- ADDR_WIDTH, 32, branch address width
- INSN_ADDR_BITS, 2, low address bits dropped before indexing
- INDEX_BITS, 6, PHT/history index width (2^INDEX_BITS entries)
- HIST_BITS, 4, local history length (counter slot select)
- CTR_WIDTH, 2, saturating counter width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid[ISSUE_WIDTH]  in  1  lane carries a resolved branch; lane 0 is oldest
- in_addr[ISSUE_WIDTH]  in  ADDR_WIDTH  branch PC
- in_taken[ISSUE_WIDTH]  in  1  executed direction
- in_mispred[ISSUE_WIDTH]  in  1  direction/target mispredicted
- in_is_cond[ISSUE_WIDTH]  in  1  conditional branch
- in_hist[ISSUE_WIDTH]  in  HIST_BITS  local history used at fetch
- in_ctr[ISSUE_WIDTH]  in  CTR_WIDTH  counter value read at fetch for slot in_hist
- in_ready  out  1  all lanes may be presented this cycle
- upd_valid  out  1  PHT write request valid
- upd_ready  in  1  predictor accepts write
- upd_index  out  INDEX_BITS  PHT entry
- upd_hist  out  HIST_BITS  counter slot within entry
- upd_ctr  out  CTR_WIDTH  new counter value
- rec_valid  out  1  history recovery request
- rec_index  out  INDEX_BITS  history register to repair
- rec_hist  out  HIST_BITS  repaired history
- init_busy  out  1  initialization sweep in progress

## Operation
- Index: in_addr[INDEX_BITS+INSN_ADDR_BITS-1 : INSN_ADDR_BITS].
- States: INIT, RUN. rst forces INIT with sweep counter = 0, queue flushed (pointers, count = 0), last-write register invalid.
- INIT: upd_valid=1, upd_index=sweep counter, upd_ctr=2^(CTR_WIDTH-1) (weakly taken), upd_hist=sweep slot. The sweep covers every (index, hist) pair, slot-minor, so it takes 2^(INDEX_BITS+HIST_BITS) accepted writes. Advance only on upd_ready. After the last pair, go to RUN. in_ready=0 and init_busy=1 throughout.
- RUN enqueue: in_ready = (DEPTH − count ≥ ISSUE_WIDTH). Each valid lane with in_is_cond=1 is written in lane order into consecutive slots. Lanes are accepted only when in_ready=1; valid lanes presented while in_ready=0 are a protocol error.
- Non-conditional valid lanes are not enqueued.
- Dequeue: upd_valid = count≠0. The head supplies index/hist. Base counter = last-write ctr if the last-write register is valid and matches the head's (index, hist); otherwise it is the entry's ctr.
- upd_ctr = taken ? min(base+1, 2^CTR_WIDTH−1) : max(base−1, 0), computed at CTR_WIDTH+1 bits to avoid wrap.
- On an upd_valid && upd_ready handshake: pop the head, and load the last-write register with that index/hist/ctr. The register is cleared on any cycle without a pop.
- Recovery: among valid lanes with in_mispred && in_is_cond, the lowest lane wins. rec_hist = {in_hist[HIST_BITS-2:0], in_taken}, rec_index = that lane's index.
- Recovery bypasses the queue and is independent of in_ready. It is ignored in INIT.
- Count width log2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Timing
- Reset values: in_ready=0, upd_valid=1 (INIT begins the cycle after rst), upd_index=0, upd_hist=0, upd_ctr=2^(CTR_WIDTH-1), rec_valid=0, rec_index=0, rec_hist=0, init_busy=1. While rst is high: upd_valid=0.
- Enqueue on edge N → entry visible at head (upd_valid) in cycle N+1. No combinational path from in_* to upd_*.
- Simultaneous push and pop: count changes by (pushes − 1). in_ready uses the pre-edge count, so a full-minus-one queue with a pop in flight still reports not ready.
- Queue full: upd_* held stable while upd_ready=0.
- Recovery: rec_valid for exactly one cycle, at N+1 after the lane is presented at N.
- rst asserted mid-sweep or mid-queue: the sweep restarts at 0 and queued entries are discarded.

## Test plan
- Reset, INDEX_BITS=2, HIST_BITS=1, upd_ready=1 → 8 writes (0,0),(0,1),(1,0)…(3,1) with ctr=2; init_busy falls after the 8th; in_ready rises the next cycle.
- Lane0 cond taken, ctr=3; lane1 cond not-taken, ctr=0 → upd_ctr 3 then 0 (both saturate), in order over 2 cycles.
- Two back-to-back entries with the same index/hist, both taken, in_ctr=1 each → upd_ctr 2 then 3 (forwarding).
- upd_ready=0 while pushing 2 per cycle with DEPTH=8 → in_ready drops after 4 pushes (count=8). Then set upd_ready=1 → in_ready returns after the pop that makes count=6.
- Lane0 and lane1 both mispredicted cond, in_hist=4'b1010, lane0 taken → rec_valid one cycle later, rec_hist=4'b0101, rec_index=lane0 index.
- rst asserted with 5 entries queued → upd_valid=0 during rst; the sweep restarts at index 0; none of the old entries are ever emitted.
